// File: rtl/inst_fetch_if.sv
// Instruction-memory request/response bundle between fetch and imem.
// Ports: imem_req/imem_addr out of fetch; imem_ready/rvalid/rdata back.
interface inst_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: one outstanding imem read, redirect, decode stall.
// Ports: clk, rst_n, imem (master), redirect/redirect_pc/stall in, inst_valid/inst/inst_pc out.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  inst_fetch_if.master imem,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  input  logic         stall,
  output logic         inst_valid,
  output logic [31:0]  inst,
  output logic [31:0]  inst_pc
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] fetch_pc_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        discard_q;
  logic        req_q;
  logic        valid_q;

  logic [31:0] tgt;
  logic        unused_rpc;

  assign tgt        = {redirect_pc[31:2], 2'b00};
  assign unused_rpc = ^redirect_pc[1:0];

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign inst_valid     = valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      discard_q  <= 1'b0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      inst_q     <= 32'h0000_0013;
      inst_pc_q  <= RESET_PC;
    end else begin
      // Redirect wins; per-state arms below never touch
      // pc_q or valid_q when redirect is high.
      if (redirect) begin
        pc_q    <= tgt;
        valid_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          state_q <= REQ;
          req_q   <= 1'b1;
        end
        REQ: begin
          if (imem.imem_ready) begin
            state_q <= WAIT;
            req_q   <= 1'b0;
            if (redirect) begin
              // Accepted fetch is for the old path.
              discard_q <= 1'b1;
            end else begin
              fetch_pc_q <= pc_q;
              pc_q       <= pc_q + 32'd4;
            end
          end
        end
        WAIT: begin
          if (imem.imem_rvalid) begin
            discard_q <= 1'b0;
            if (!redirect && !discard_q) begin
              inst_q    <= imem.imem_rdata;
              inst_pc_q <= fetch_pc_q;
              valid_q   <= 1'b1;
              state_q   <= HOLD;
            end else begin
              state_q <= REQ;
              req_q   <= 1'b1;
            end
          end else if (redirect) begin
            discard_q <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect || !stall) begin
            valid_q <= 1'b0;
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch against a transaction-level fetch model.
// Ports: none; drives the imem slave side, redirect, stall and reset.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  inst_fetch_if imem ();

  inst_fetch #(
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem       (imem),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .stall      (stall),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc)
  );

  int n_vec;
  int n_err;

  // Model: a request is wanted whenever nothing is
  // outstanding and nothing is presented to decode.
  bit          m_idle;
  bit          m_out;
  bit          m_live;
  bit          m_hold;
  logic [31:0] m_pc;
  logic [31:0] m_oaddr;
  logic [31:0] m_inst;
  logic [31:0] m_ipc;
  int          lat;

  int p_ready;
  int p_redir;
  int p_stall;
  int max_lat;
  int p_spur;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset;
    m_idle  = 1'b1;
    m_out   = 1'b0;
    m_live  = 1'b0;
    m_hold  = 1'b0;
    m_pc    = 32'h0;
    m_oaddr = 32'h0;
    m_inst  = 32'h0000_0013;
    m_ipc   = 32'h0;
    lat     = 0;
  endtask

  function automatic bit exp_req();
    return !m_idle && !m_out && !m_hold;
  endfunction

  task automatic m_step;
    bit acc;
    bit ret;
    if (!rst_n) begin
      m_reset();
      return;
    end
    if (m_idle) begin
      m_idle = 1'b0;
      if (redirect) m_pc = redirect_pc & 32'hFFFF_FFFC;
      return;
    end
    acc = exp_req() && imem.imem_ready;
    ret = m_out && imem.imem_rvalid;
    if (m_hold && (redirect || !stall)) m_hold = 1'b0;
    if (ret) begin
      m_out = 1'b0;
      if (m_live && !redirect) begin
        m_hold = 1'b1;
        m_inst = mem_word(m_oaddr);
        m_ipc  = m_oaddr;
      end
    end else if (m_out && redirect) begin
      m_live = 1'b0;
    end
    if (acc) begin
      m_out   = 1'b1;
      m_oaddr = m_pc;
      m_live  = !redirect;
      m_pc    = m_pc + 32'd4;
      lat     = $urandom_range(max_lat);
    end
    if (redirect) m_pc = redirect_pc & 32'hFFFF_FFFC;
  endtask

  task automatic drive;
    redirect = ($urandom_range(99) < p_redir);
    case ($urandom_range(3))
      0: redirect_pc = $urandom;
      1: redirect_pc = 32'hFFFF_FFF0 | $urandom_range(15);
      2: redirect_pc = 32'h0000_0100;
      default: redirect_pc = 32'h0000_0203;
    endcase
    stall = ($urandom_range(99) < p_stall);
    imem.imem_ready = ($urandom_range(99) < p_ready);
    if (m_out) begin
      if (lat == 0) begin
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = mem_word(m_oaddr);
      end else begin
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = $urandom;
        lat--;
      end
    end else begin
      imem.imem_rvalid = ($urandom_range(99) < p_spur);
      imem.imem_rdata  = $urandom;
    end
  endtask

  task automatic check_out;
    chk("imem_req", {31'b0, imem.imem_req}, {31'b0, exp_req()});
    chk("imem_addr", imem.imem_addr, m_pc);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_hold});
    chk("inst", inst, m_inst);
    chk("inst_pc", inst_pc, m_ipc);
  endtask

  task automatic cycle;
    @(posedge clk);
    m_step();
    @(negedge clk);
    check_out();
  endtask

  task automatic set_knobs(input int r, input int d, input int s,
                           input int l, input int sp);
    p_ready = r;
    p_redir = d;
    p_stall = s;
    max_lat = l;
    p_spur  = sp;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      drive();
      cycle();
    end
  endtask

  task automatic kick(input logic [31:0] t);
    drive();
    redirect    = 1'b1;
    redirect_pc = t;
    cycle();
  endtask

  task automatic mid_reset;
    int k;
    k = 0;
    while (!m_out && k < 50) begin
      drive();
      cycle();
      k++;
    end
    chk("reach_wait", {31'b0, m_out}, 32'd1);
    drive();
    #2 rst_n = 1'b0;
    #1 m_reset();
    check_out();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    stall       = 1'b0;
    imem.imem_ready  = 1'b0;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = 32'h0;
    m_reset();
    set_knobs(100, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check_out();
    rst_n = 1'b1;

    run(30);
    set_knobs(20, 0, 0, 0, 0);
    run(40);
    set_knobs(100, 0, 60, 0, 0);
    run(40);
    set_knobs(100, 0, 0, 0, 0);
    kick(32'hFFFF_FFFF);
    run(12);
    kick(32'h0000_0203);
    run(12);
    set_knobs(70, 15, 30, 3, 10);
    run(1500);
    for (int i = 0; i < 4; i++) begin
      mid_reset();
      set_knobs(60, 10, 30, 2, 15);
      run(200);
    end
    set_knobs(90, 30, 20, 1, 20);
    run(1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 imem_req  output  1  SHALL flag a valid instruction-memory read request.
REQ-005 imem_addr  output  32  SHALL carry the word-aligned fetch address.
REQ-006 imem_ready  input  1  SHALL signal acceptance of the request in the current cycle.
REQ-007 imem_rvalid  input  1  SHALL signal that imem_rdata holds the read data, at least 1 cycle after acceptance.
REQ-008 imem_rdata  input  32  SHALL carry the fetched instruction word.
REQ-009 redirect  input  1  SHALL be a one-cycle pulse requesting a PC change (taken branch, jal, jalr).
REQ-010 redirect_pc  input  32  SHALL carry the redirect target; bits [1:0] ignored.
REQ-011 stall  input  1  SHALL signal that the decode stage cannot consume the presented instruction.
REQ-012 inst_valid  output  1  SHALL flag that inst/inst_pc hold a valid instruction for the decoder.
REQ-013 inst  output  32  SHALL be the registered instruction word driven to the controller/decoder.
REQ-014 inst_pc  output  32  SHALL be the fetch address of inst.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT, HOLD; one request outstanding at most.
REQ-016 IDLE SHALL drive imem_req=0 and go to REQ next cycle.
REQ-017 REQ SHALL drive imem_req=1, imem_addr=pc; on imem_ready: fetch_pc<=pc, pc<=pc+4, go WAIT; else stay REQ with imem_addr stable.
REQ-018 WAIT SHALL drive imem_req=0; on imem_rvalid with discard=0: inst<=imem_rdata, inst_pc<=fetch_pc, inst_valid<=1, go HOLD.
REQ-019 HOLD SHALL keep inst, inst_pc, inst_valid=1 stable while stall=1; on stall=0 the word is consumed at that edge: inst_valid<=0, go REQ.
REQ-020 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000; no overflow flag.
REQ-021 redirect SHALL take priority over every other event: pc<={redirect_pc[31:2],2'b00}, inst_valid<=0.
REQ-022 redirect in IDLE or HOLD SHALL go REQ; stall ignored in that cycle.
REQ-023 redirect in REQ with imem_ready=0 SHALL stay REQ; next cycle imem_addr = new pc.
REQ-024 redirect in REQ with imem_ready=1 SHALL set discard=1, go WAIT; pc not incremented.
REQ-025 redirect in WAIT with imem_rvalid=0 SHALL set discard=1, stay WAIT.
REQ-026 redirect in WAIT with imem_rvalid=1 SHALL drop the data, go REQ.
REQ-027 WAIT with imem_rvalid=1 and discard=1 SHALL drop the data, clear discard, go REQ; inst_valid stays 0.
REQ-028 imem_rvalid outside WAIT SHALL be ignored.
REQ-029 Throughput SHALL be one instruction per 3 cycles minimum (REQ accept, rvalid, HOLD consume), zero-wait memory.

Reset
REQ-030 rst_n=0 SHALL immediately force state=IDLE, pc=RESET_PC, fetch_pc=RESET_PC, discard=0, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=32'h0000_0013 (nop), inst_pc=RESET_PC.
REQ-031 Reset asserted mid-request SHALL abandon it; a later imem_rvalid SHALL be ignored since state is IDLE/REQ.
REQ-032 First imem_req SHALL assert in the second cycle after rst_n deasserts (IDLE, then REQ).

Verification
REQ-033 Reset release, RESET_PC=0, zero-wait memory returning addr-based words, stall=0 -> inst_pc sequence 0x0,0x4,0x8, inst_valid pulsing once every 3 cycles.
REQ-034 imem_ready held 0 for 4 cycles -> imem_req=1 and imem_addr=0x4 stable all 4 cycles, single accept.
REQ-035 stall=1 for 5 cycles in HOLD with inst=0x00500093 -> inst/inst_pc/inst_valid unchanged, no new imem_req until stall drops.
REQ-036 redirect to 0x100 in WAIT, rvalid 2 cycles later with 0xDEADBEEF -> word dropped, inst_valid stays 0, next imem_addr=0x100.
REQ-037 redirect to 0x203 in same cycle as imem_ready -> following rvalid dropped, next imem_addr=0x200.
REQ-038 pc=0xFFFFFFFC accepted -> next imem_addr=0x00000000; rst_n pulsed low in WAIT -> outputs at REQ-030 values within same cycle.
